ard_rx_frame_decoder: RTL and testbench
=======================================

Name: ard_rx_frame_decoder

Overview:
- Serial command receiver upstream of the elevator controller.
- Receives 8N1 UART bytes from the Arduino panel, assembles fixed 8-byte button frames, verifies sync and checksum.
- Emits one-cycle "new button" masks (hall buttons + three cars' internal buttons) that the controller ORs into its pending-request state.

Parameters:
- CLKFRQ, 100000000, system clock frequency in Hz.
- BAUDRATE, 9600, serial bit rate. CLKS_PER_BIT = CLKFRQ/BAUDRATE (integer division, must be >= 4).
- TIMEOUT_BITS, 30, inter-byte idle limit in bit periods while a frame is in progress.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  receive enable; low forces idle.
- rx  input  1  asynchronous UART line, idle high.
- newRealFloorButton  output  12  hall-button request mask, one-cycle pulse.
- newInternalButton1  output  9 ([9:1])  car 1 internal-button mask, pulse.
- newInternalButton2  output  9 ([9:1])  car 2 internal-button mask, pulse.
- newInternalButton3  output  9 ([9:1])  car 3 internal-button mask, pulse.
- frame_valid  output  1  pulse; good frame delivered.
- frame_error  output  1  pulse; frame discarded.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; rx synchronizer flops = 1; bit FSM IDLE; frame parser HUNT; all counters 0.
- rx passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized 1->0 transition.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. Low -> DATA. High -> IDLE (glitch; no byte, no error).
  - DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
  - STOP: sample once after a further CLKS_PER_BIT. 1 -> byte_done. 0 -> byte_err. Either way -> IDLE.
- Frame format (byte index 0..7):
  - B0 = 0xA5 sync
  - B1 = real[7:0]
  - B2 = {4'b0, real[11:8]}
  - B3 = int1[8:1]; B4 = int2[8:1]; B5 = int3[8:1]
  - B6 = {5'b0, int3[9], int2[9], int1[9]}
  - B7 = XOR of B1..B6
  - Reserved bits are ignored.
- Parser states: HUNT, PAYLOAD (index 1..6), CHECK.
  - HUNT: bytes other than 0xA5 are discarded silently. 0xA5 -> PAYLOAD, index 1.
  - PAYLOAD: each byte_done stores the byte and updates the running XOR. 0xA5 inside the payload is data; no resync.
  - After B6 -> CHECK.
  - CHECK, B7 equals running XOR: on the cycle after the B7 stop-bit sample, drive the new* outputs with the decoded fields and frame_valid=1 for exactly 1 cycle. Return to HUNT.
  - CHECK, B7 mismatch: frame_error=1 for 1 cycle, new* stay 0, return to HUNT.
- byte_err (framing error) in any state: frame_error pulse (in HUNT also); parser -> HUNT.
- Timeout: in PAYLOAD/CHECK, a counter runs between byte_done events. Reaching TIMEOUT_BITS*CLKS_PER_BIT cycles with the bit FSM in IDLE -> frame_error pulse, parser -> HUNT.
- en low: bit FSM forced IDLE, parser forced HUNT, counters cleared, no pulses. Dropping en mid-frame aborts silently. On en rising, a line already low is not treated as a start; a fresh 1->0 edge is required.
- frame_valid and frame_error are never asserted in the same cycle. Outputs are registered and are 0 in every non-pulse cycle.
- Reset mid-byte or mid-frame: state identical to post-reset; any partial frame is lost.

Optional Feature:
- Macro ARD_RX_PARITY_EN.
- Defined: a 9th bit (even parity over the 8 data bits) is sampled between DATA and STOP (new state PARITY). A mismatch is treated exactly as byte_err.
- Undefined: 8N1 as described; no PARITY state.

Test Plan:
- Bench settings for all cases: CLKFRQ=1000, BAUDRATE=100 (10 clk/bit).
- Frame A5 03 00 05 00 80 01 87 -> one-cycle frame_valid; newRealFloorButton=12'h003, newInternalButton1=9'h105, newInternalButton2=9'h000, newInternalButton3=9'h080; all outputs 0 the next cycle.
- Same frame with B7=86 -> frame_error pulse once; frame_valid and all new* stay 0.
- rx low for 3 cycles then high, followed by the valid frame -> no error from the glitch; frame_valid for the frame.
- Stop bit forced 0 in B3, then the valid frame -> one frame_error, then frame_valid with the correct masks.
- Send A5 02, then idle 300 cycles -> frame_error at 300 cycles after the B1 stop sample; a following valid frame decodes correctly.
- en deasserted during B4, reasserted, then the valid frame -> no pulse for the aborted frame, frame_valid for the new one.
- With ARD_RX_PARITY_EN: a wrong parity bit on B5 -> frame_error.

Source files
------------

// File: rtl/ard_rx_frame_decoder.sv
// ard_rx_frame_decoder: UART (8N1) receiver plus fixed 8-byte button-frame parser.
// Frame: A5 sync, six payload bytes, XOR checksum. Good frames emit one-cycle
// "new button" masks with frame_valid; bad/timed-out frames pulse frame_error.
// Optional macro ARD_RX_PARITY_EN adds an even-parity bit after the data bits.
module ard_rx_frame_decoder #(
  parameter int CLKFRQ       = 100000000,
  parameter int BAUDRATE     = 9600,
  parameter int TIMEOUT_BITS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        rx,
  output logic [11:0] newRealFloorButton,
  output logic [9:1]  newInternalButton1,
  output logic [9:1]  newInternalButton2,
  output logic [9:1]  newInternalButton3,
  output logic        frame_valid,
  output logic        frame_error
);

  localparam int CLKS_PER_BIT = CLKFRQ / BAUDRATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int TW           = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    SYNC      = 8'hA5;

  typedef enum logic [2:0] {
    B_IDLE, B_START, B_DATA, B_STOP
`ifdef ARD_RX_PARITY_EN
    , B_PARITY
`endif
  } bit_state_e;

  typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CHECK} par_state_e;

  logic rx_s1_q, rx_s2_q, rx_prev_q;

  bit_state_e bit_state_q, bit_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          byte_done, byte_err;

  par_state_e    pstate_q, pstate_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    xor_q, xor_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [11:0]   real_q, real_d;
  logic [9:1]    i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;

  logic [11:0]   out_real_q, out_real_d;
  logic [9:1]    out_i1_q, out_i1_d, out_i2_q, out_i2_d, out_i3_q, out_i3_d;
  logic          fv_q, fv_d, fe_q, fe_d;

  // Two-flop synchronizer plus previous-sample flop for start-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Bit-level receive FSM: start validation, mid-bit sampling, stop check.
  always_comb begin
    bit_state_d = bit_state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    byte_done   = 1'b0;
    byte_err    = 1'b0;
    case (bit_state_q)
      B_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) bit_state_d = B_START;
      end
      B_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d       = '0;
          bit_idx_d   = '0;
          bit_state_d = rx_s2_q ? B_IDLE : B_DATA;
        end else cnt_d = cnt_q + 1'b1;
      end
      B_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shreg_d   = {rx_s2_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef ARD_RX_PARITY_EN
          if (bit_idx_q == 3'd7) bit_state_d = B_PARITY;
`else
          if (bit_idx_q == 3'd7) bit_state_d = B_STOP;
`endif
        end else cnt_d = cnt_q + 1'b1;
      end
`ifdef ARD_RX_PARITY_EN
      B_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s2_q != ^shreg_q) begin
            byte_err    = 1'b1;
            bit_state_d = B_IDLE;
          end else bit_state_d = B_STOP;
        end else cnt_d = cnt_q + 1'b1;
      end
`endif
      B_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          bit_state_d = B_IDLE;
          if (rx_s2_q) byte_done = 1'b1;
          else         byte_err  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: bit_state_d = B_IDLE;
    endcase
    if (!en) begin
      bit_state_d = B_IDLE;
      cnt_d       = '0;
      bit_idx_d   = '0;
      byte_done   = 1'b0;
      byte_err    = 1'b0;
    end
  end

  // Frame parser: sync hunt, payload capture with running XOR, checksum, timeout.
  always_comb begin
    pstate_d   = pstate_q;
    idx_d      = idx_q;
    xor_d      = xor_q;
    real_d     = real_q;
    i1_d       = i1_q;
    i2_d       = i2_q;
    i3_d       = i3_q;
    out_real_d = '0;
    out_i1_d   = '0;
    out_i2_d   = '0;
    out_i3_d   = '0;
    fv_d       = 1'b0;
    fe_d       = 1'b0;
    to_cnt_d   = '0;
    if (pstate_q != P_HUNT)
      to_cnt_d = (to_cnt_q < TO_LAST) ? to_cnt_q + 1'b1 : to_cnt_q;
    if (byte_done) to_cnt_d = TW'(1);
    case (pstate_q)
      P_HUNT: begin
        if (byte_done && shreg_q == SYNC) begin
          pstate_d = P_PAYLOAD;
          idx_d    = 3'd1;
          xor_d    = '0;
        end
      end
      P_PAYLOAD: begin
        if (byte_done) begin
          xor_d = xor_q ^ shreg_q;
          case (idx_q)
            3'd1: real_d[7:0]  = shreg_q;
            3'd2: real_d[11:8] = shreg_q[3:0];
            3'd3: i1_d[8:1]    = shreg_q;
            3'd4: i2_d[8:1]    = shreg_q;
            3'd5: i3_d[8:1]    = shreg_q;
            default: begin
              i1_d[9] = shreg_q[0];
              i2_d[9] = shreg_q[1];
              i3_d[9] = shreg_q[2];
            end
          endcase
          if (idx_q == 3'd6) pstate_d = P_CHECK;
          else               idx_d    = idx_q + 3'd1;
        end
      end
      P_CHECK: begin
        if (byte_done) begin
          pstate_d = P_HUNT;
          if (shreg_q == xor_q) begin
            fv_d       = 1'b1;
            out_real_d = real_q;
            out_i1_d   = i1_q;
            out_i2_d   = i2_q;
            out_i3_d   = i3_q;
          end else fe_d = 1'b1;
        end
      end
      default: pstate_d = P_HUNT;
    endcase
    if (byte_err) begin
      fe_d     = 1'b1;
      pstate_d = P_HUNT;
    end
    // byte_done only fires in STOP, so the idle-gated timeout never collides with it.
    if (pstate_q != P_HUNT && bit_state_q == B_IDLE && to_cnt_q >= TO_LAST) begin
      fe_d     = 1'b1;
      pstate_d = P_HUNT;
    end
    if (!en) begin
      pstate_d   = P_HUNT;
      idx_d      = '0;
      xor_d      = '0;
      to_cnt_d   = '0;
      fv_d       = 1'b0;
      fe_d       = 1'b0;
      out_real_d = '0;
      out_i1_d   = '0;
      out_i2_d   = '0;
      out_i3_d   = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_state_q <= B_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      pstate_q    <= P_HUNT;
      idx_q       <= '0;
      xor_q       <= '0;
      to_cnt_q    <= '0;
      real_q      <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
      i3_q        <= '0;
      out_real_q  <= '0;
      out_i1_q    <= '0;
      out_i2_q    <= '0;
      out_i3_q    <= '0;
      fv_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      bit_state_q <= bit_state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      pstate_q    <= pstate_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      to_cnt_q    <= to_cnt_d;
      real_q      <= real_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
      out_real_q  <= out_real_d;
      out_i1_q    <= out_i1_d;
      out_i2_q    <= out_i2_d;
      out_i3_q    <= out_i3_d;
      fv_q        <= fv_d;
      fe_q        <= fe_d;
    end
  end

  assign newRealFloorButton = out_real_q;
  assign newInternalButton1 = out_i1_q;
  assign newInternalButton2 = out_i2_q;
  assign newInternalButton3 = out_i3_q;
  assign frame_valid        = fv_q;
  assign frame_error        = fe_q;

endmodule

// File: tb/tb_ard_rx_frame_decoder.sv
// Directed bench for ard_rx_frame_decoder at 10 clocks per bit.
module tb_ard_rx_frame_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic        rx = 1'b1;
  logic [11:0] newRealFloorButton;
  logic [9:1]  newInternalButton1, newInternalButton2, newInternalButton3;
  logic        frame_valid, frame_error;

  always #5 clk = ~clk;

  ard_rx_frame_decoder #(.CLKFRQ(1000), .BAUDRATE(100), .TIMEOUT_BITS(30)) dut (
    .clk(clk), .reset(reset), .en(en), .rx(rx),
    .newRealFloorButton(newRealFloorButton),
    .newInternalButton1(newInternalButton1),
    .newInternalButton2(newInternalButton2),
    .newInternalButton3(newInternalButton3),
    .frame_valid(frame_valid), .frame_error(frame_error)
  );

  localparam logic [63:0] GOOD = 64'hA5_03_00_05_00_80_01_87;
  localparam logic [63:0] BADX = 64'hA5_03_00_05_00_80_01_86;
  localparam logic [63:0] ALT  = 64'hA5_A5_F3_FF_00_A5_FF_F3;

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  int fv_cnt = 0, fe_cnt = 0, both_cnt = 0, stray_cnt = 0, wide_cnt = 0;
  int fv_cyc = 0, fe_cyc = 0, b7_cyc = 0;
  logic [11:0] cap_real = '0;
  logic [9:1]  cap_i1 = '0, cap_i2 = '0, cap_i3 = '0;
  logic prev_fv = 1'b0, prev_fe = 1'b0;
`ifdef ARD_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Record pulses and any output activity outside a frame_valid cycle.
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt++; fv_cyc = cyc;
      cap_real = newRealFloorButton; cap_i1 = newInternalButton1;
      cap_i2 = newInternalButton2;   cap_i3 = newInternalButton3;
    end
    if (frame_error) begin fe_cnt++; fe_cyc = cyc; end
    if (frame_valid && frame_error) both_cnt++;
    if (!frame_valid && (newRealFloorButton != 0 || newInternalButton1 != 0 ||
        newInternalButton2 != 0 || newInternalButton3 != 0)) stray_cnt++;
    if ((frame_valid && prev_fv) || (frame_error && prev_fe)) wide_cnt++;
    prev_fv = frame_valid;
    prev_fe = frame_error;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0; wait_clks(10);
    for (int i = 0; i < 8; i++) begin rx = b[i]; wait_clks(10); end
`ifdef ARD_RX_PARITY_EN
    rx = (^b) ^ par_flip; wait_clks(10);
`endif
    rx = stop_bit; wait_clks(10);
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) b7_cyc = cyc;
      send_byte(f[63-8*i -: 8], 1'b1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1; rx = 1'b1;
    wait_clks(4);
    n_checks++;
    if ({frame_valid, frame_error, newRealFloorButton, newInternalButton1,
         newInternalButton2, newInternalButton3} !== 41'd0)
      $display("FAIL reset_outputs: got fv=%b fe=%b real=%h expected all 0",
               frame_valid, frame_error, newRealFloorButton);
    else n_pass++;
    reset = 1'b0;
    wait_clks(10);
    n_checks++;
    if (fv_cnt + fe_cnt !== 0) $display("FAIL post_reset_idle: got %0d pulses expected 0", fv_cnt + fe_cnt);
    else n_pass++;
  endtask

  task automatic test_good_frame;
    int fv0 = fv_cnt, fe0 = fe_cnt, lat;
    send_frame(GOOD); wait_clks(20);
    lat = fv_cyc - b7_cyc;
    n_checks++; if (fv_cnt - fv0 !== 1) $display("FAIL good_fv_count: got %0d expected 1", fv_cnt - fv0); else n_pass++;
    n_checks++; if (fe_cnt - fe0 !== 0) $display("FAIL good_fe_count: got %0d expected 0", fe_cnt - fe0); else n_pass++;
    n_checks++; if (cap_real !== 12'h003) $display("FAIL good_real: got %h expected 003", cap_real); else n_pass++;
    n_checks++; if (cap_i1 !== 9'h105) $display("FAIL good_int1: got %h expected 105", cap_i1); else n_pass++;
    n_checks++; if (cap_i2 !== 9'h000) $display("FAIL good_int2: got %h expected 000", cap_i2); else n_pass++;
    n_checks++; if (cap_i3 !== 9'h080) $display("FAIL good_int3: got %h expected 080", cap_i3); else n_pass++;
    n_checks++; if (lat < 96 || lat > 100) $display("FAIL good_latency: got %0d expected 96..100", lat); else n_pass++;
    n_checks++; if (stray_cnt !== 0 || wide_cnt !== 0)
      $display("FAIL good_one_cycle: got stray=%0d wide=%0d expected 0/0", stray_cnt, wide_cnt); else n_pass++;
  endtask

  task automatic test_bad_checksum;
    int fv0 = fv_cnt, fe0 = fe_cnt, s0 = stray_cnt;
    send_frame(BADX); wait_clks(20);
    n_checks++; if (fe_cnt - fe0 !== 1) $display("FAIL badsum_fe_count: got %0d expected 1", fe_cnt - fe0); else n_pass++;
    n_checks++; if (fv_cnt - fv0 !== 0) $display("FAIL badsum_fv_count: got %0d expected 0", fv_cnt - fv0); else n_pass++;
    n_checks++; if (stray_cnt - s0 !== 0) $display("FAIL badsum_masks: got %0d nonzero cycles expected 0", stray_cnt - s0); else n_pass++;
  endtask

  task automatic test_glitch;
    int fv0 = fv_cnt, fe0 = fe_cnt;
    rx = 1'b0; wait_clks(3); rx = 1'b1; wait_clks(30);
    n_checks++; if (fe_cnt - fe0 !== 0) $display("FAIL glitch_fe: got %0d expected 0", fe_cnt - fe0); else n_pass++;
    send_frame(GOOD); wait_clks(20);
    n_checks++; if (fv_cnt - fv0 !== 1) $display("FAIL glitch_fv: got %0d expected 1", fv_cnt - fv0); else n_pass++;
    n_checks++; if (cap_i1 !== 9'h105) $display("FAIL glitch_int1: got %h expected 105", cap_i1); else n_pass++;
  endtask

  task automatic test_stop_error;
    int fv0 = fv_cnt, fe0 = fe_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b0);
    rx = 1'b1; wait_clks(30);
    n_checks++; if (fe_cnt - fe0 !== 1) $display("FAIL stoperr_fe: got %0d expected 1", fe_cnt - fe0); else n_pass++;
    send_frame(GOOD); wait_clks(20);
    n_checks++; if (fv_cnt - fv0 !== 1) $display("FAIL stoperr_fv: got %0d expected 1", fv_cnt - fv0); else n_pass++;
    n_checks++; if (fe_cnt - fe0 !== 1) $display("FAIL stoperr_fe_total: got %0d expected 1", fe_cnt - fe0); else n_pass++;
    n_checks++; if (cap_real !== 12'h003 || cap_i3 !== 9'h080)
      $display("FAIL stoperr_masks: got real=%h int3=%h expected 003/080", cap_real, cap_i3); else n_pass++;
  endtask

  task automatic test_timeout;
    int fv0 = fv_cnt, fe0 = fe_cnt, c0, dt;
    send_byte(8'hA5, 1'b1);
    c0 = cyc;
    send_byte(8'h02, 1'b1);
    rx = 1'b1; wait_clks(250);
    n_checks++; if (fe_cnt - fe0 !== 0) $display("FAIL timeout_early: got %0d expected 0", fe_cnt - fe0); else n_pass++;
    wait_clks(100);
    dt = fe_cyc - c0;
    n_checks++; if (fe_cnt - fe0 !== 1) $display("FAIL timeout_fe: got %0d expected 1", fe_cnt - fe0); else n_pass++;
    n_checks++; if (dt < 395 || dt > 399) $display("FAIL timeout_cycle: got %0d expected 395..399", dt); else n_pass++;
    send_frame(GOOD); wait_clks(20);
    n_checks++; if (fv_cnt - fv0 !== 1 || cap_i1 !== 9'h105)
      $display("FAIL timeout_recover: got fv=%0d int1=%h expected 1/105", fv_cnt - fv0, cap_i1); else n_pass++;
  endtask

  task automatic test_en_abort;
    int fv0 = fv_cnt, fe0 = fe_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    rx = 1'b0; wait_clks(25);
    en = 1'b0; rx = 1'b1; wait_clks(30);
    rx = 1'b0; wait_clks(10);
    en = 1'b1; wait_clks(120);
    rx = 1'b1; wait_clks(30);
    n_checks++; if (fv_cnt - fv0 !== 0 || fe_cnt - fe0 !== 0)
      $display("FAIL en_abort_silent: got fv=%0d fe=%0d expected 0/0", fv_cnt - fv0, fe_cnt - fe0); else n_pass++;
    send_frame(GOOD); wait_clks(20);
    n_checks++; if (fv_cnt - fv0 !== 1 || fe_cnt - fe0 !== 0)
      $display("FAIL en_abort_next: got fv=%0d fe=%0d expected 1/0", fv_cnt - fv0, fe_cnt - fe0); else n_pass++;
  endtask

  task automatic test_sync_in_payload;
    int fv0 = fv_cnt, fe0 = fe_cnt;
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_frame(ALT); wait_clks(20);
    n_checks++; if (fv_cnt - fv0 !== 1 || fe_cnt - fe0 !== 0)
      $display("FAIL alt_counts: got fv=%0d fe=%0d expected 1/0", fv_cnt - fv0, fe_cnt - fe0); else n_pass++;
    n_checks++; if (cap_real !== 12'h3A5) $display("FAIL alt_real: got %h expected 3a5", cap_real); else n_pass++;
    n_checks++; if ({cap_i1, cap_i2, cap_i3} !== {9'h1FF, 9'h100, 9'h1A5})
      $display("FAIL alt_int: got %h %h %h expected 1ff 100 1a5", cap_i1, cap_i2, cap_i3); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int fv0 = fv_cnt, fe0 = fe_cnt;
    send_frame(GOOD); send_frame(ALT); wait_clks(20);
    n_checks++; if (fv_cnt - fv0 !== 2 || fe_cnt - fe0 !== 0)
      $display("FAIL b2b_counts: got fv=%0d fe=%0d expected 2/0", fv_cnt - fv0, fe_cnt - fe0); else n_pass++;
    n_checks++; if (cap_i3 !== 9'h1A5) $display("FAIL b2b_last_int3: got %h expected 1a5", cap_i3); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int fv0 = fv_cnt, fe0 = fe_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1);
    rx = 1'b0; wait_clks(25);
    reset = 1'b1; rx = 1'b1; wait_clks(3);
    reset = 1'b0; wait_clks(20);
    send_frame(GOOD); wait_clks(20);
    n_checks++; if (fv_cnt - fv0 !== 1 || fe_cnt - fe0 !== 0)
      $display("FAIL reset_mid_frame: got fv=%0d fe=%0d expected 1/0", fv_cnt - fv0, fe_cnt - fe0); else n_pass++;
  endtask

`ifdef ARD_RX_PARITY_EN
  task automatic test_parity;
    int fv0 = fv_cnt, fe0 = fe_cnt;
    for (int i = 0; i < 8; i++) begin
      par_flip = (i == 5);
      send_byte(GOOD[63-8*i -: 8], 1'b1);
    end
    par_flip = 1'b0;
    wait_clks(20);
    n_checks++; if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0)
      $display("FAIL parity_err: got fe=%0d fv=%0d expected 1/0", fe_cnt - fe0, fv_cnt - fv0); else n_pass++;
    send_frame(GOOD); wait_clks(20);
    n_checks++; if (fv_cnt - fv0 !== 1) $display("FAIL parity_recover: got %0d expected 1", fv_cnt - fv0); else n_pass++;
  endtask
`endif

  task automatic test_exclusive;
    n_checks++; if (both_cnt !== 0) $display("FAIL exclusive_pulses: got %0d expected 0", both_cnt); else n_pass++;
    n_checks++; if (stray_cnt !== 0 || wide_cnt !== 0)
      $display("FAIL pulse_shape: got stray=%0d wide=%0d expected 0/0", stray_cnt, wide_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_glitch();
    test_stop_error();
    test_timeout();
    test_en_abort();
    test_sync_in_payload();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef ARD_RX_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
